// File: rtl/ysyx_25030093_ifu_fetch.sv
// ----------------------------------------------------------------------------
// ysyx_25030093_ifu_fetch
//
// Instruction fetch stage for the multi-cycle core. Holds the PC, issues one
// read per instruction on an AXI4-Lite-style AR/R channel, hands the fetched
// word and its PC to decode over a valid/ready handshake, then waits for
// write-back to supply the next PC. A bus error, a misaligned PC or a response
// timeout parks the stage in a sticky error state that only reset leaves.
//
// Parameters:
//   RESET_PC        PC loaded on reset; address of the first fetch
//   TIMEOUT_CYCLES  cycles allowed in WAIT before a timeout error (1..65535)
//
// Ports:
//   clock      system clock, all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   araddr     read address (always the current pc)
//   arvalid    read address valid
//   arready    read address accepted by the bus
//   rdata      read data
//   rresp      read response, 2'b00 = OKAY, anything else is an error
//   rvalid     read data valid
//   rready     ready to accept read data
//   inst       captured instruction word for decode
//   inst_pc    PC of inst
//   out_valid  inst/inst_pc valid for decode
//   in_ready   decode ready to accept
//   npc_valid  write-back pulse: next PC available
//   npc        next PC from write-back
//   fetch_err  sticky error flag
// ----------------------------------------------------------------------------
module ysyx_25030093_ifu_fetch #(
   parameter logic [31:0] RESET_PC       = 32'h8000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   // read address channel
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   // read data channel
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   // decode side
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        out_valid,
   input  logic        in_ready,
   // write-back side
   input  logic        npc_valid,
   input  logic [31:0] npc,
   // status
   output logic        fetch_err
);

   localparam logic [31:0] NopInst = 32'h0000_0013;
   // Last counter value tolerated before the timeout fires.
   localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StBoot,
      StReq,
      StWait,
      StHold,
      StExec,
      StErr
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [15:0] cnt_q, cnt_d;

   logic pc_aligned;
   logic r_okay;
   logic r_error;
   logic timeout;

   assign pc_aligned = (pc_q[1:0] == 2'b00);
   assign r_okay     = rvalid && (rresp == 2'b00);
   assign r_error    = rvalid && (rresp != 2'b00);
   assign timeout    = !rvalid && (cnt_q == CntLast);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StBoot;
         pc_q      <= RESET_PC;
         inst_q    <= NopInst;
         inst_pc_q <= RESET_PC;
         cnt_q     <= 16'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         cnt_q     <= cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         StBoot: state_d = StReq;
         StReq: begin
            // A misaligned pc traps before anything reaches the bus.
            if (!pc_aligned) begin
               state_d = StErr;
            end else if (arready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (r_okay) begin
               state_d = StHold;
            end else if (r_error || timeout) begin
               state_d = StErr;
            end
         end
         StHold: begin
            if (in_ready) begin
               state_d = StExec;
            end
         end
         StExec: begin
            if (npc_valid) begin
               state_d = StReq;
            end
         end
         StErr:   state_d = StErr;
         default: state_d = StErr;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath next-state: pc, captured instruction and WAIT counter
   // -------------------------------------------------------------------------
   always_comb begin
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      cnt_d     = 16'd0;

      if ((state_q == StExec) && npc_valid) begin
         pc_d = npc;
      end

      if ((state_q == StWait) && r_okay) begin
         inst_d    = rdata;
         inst_pc_d = pc_q;
      end

      // The counter only runs while staying in WAIT; any exit clears it.
      if ((state_q == StWait) && (state_d == StWait)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs, decoded from registered state only
   // -------------------------------------------------------------------------
   always_comb begin
      arvalid   = 1'b0;
      rready    = 1'b0;
      out_valid = 1'b0;
      fetch_err = 1'b0;
      case (state_q)
         StReq:   arvalid   = pc_aligned;
         StWait:  rready    = 1'b1;
         StHold:  out_valid = 1'b1;
         StErr:   fetch_err = 1'b1;
         default: ;
      endcase
   end

   assign araddr  = pc_q;
   assign inst    = inst_q;
   assign inst_pc = inst_pc_q;

endmodule

// File: tb/tb_ysyx_25030093_ifu_fetch.sv
module tb_ysyx_25030093_ifu_fetch;

   localparam logic [31:0] RstPc = 32'h8000_0000;

   logic        clock;
   logic        reset;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        out_valid;
   logic        in_ready;
   logic        npc_valid;
   logic [31:0] npc;
   logic        fetch_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];

   ysyx_25030093_ifu_fetch #(
      .RESET_PC      (RstPc),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .araddr   (araddr),
      .arvalid  (arvalid),
      .arready  (arready),
      .rdata    (rdata),
      .rresp    (rresp),
      .rvalid   (rvalid),
      .rready   (rready),
      .inst     (inst),
      .inst_pc  (inst_pc),
      .out_valid(out_valid),
      .in_ready (in_ready),
      .npc_valid(npc_valid),
      .npc      (npc),
      .fetch_err(fetch_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drive an OKAY read response and record what decode must later see.
   task automatic respond(input logic [31:0] data, input logic [31:0] pc);
      exp_t e;
      rvalid = 1'b1;
      rdata  = data;
      rresp  = 2'b00;
      e.inst = data;
      e.pc   = pc;
      sb.push_back(e);
   endtask

   // Compare the presented instruction against the oldest scoreboard entry.
   task automatic pop_check(input string tag);
      exp_t e;
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s_sb_empty observed=empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_inst"}, inst, e.inst);
         chk({tag, "_inst_pc"}, inst_pc, e.pc);
      end
   endtask

   // Full fetch starting in REQ, ending in EXEC.
   task automatic fetch_ok(input string tag, input logic [31:0] addr, input logic [31:0] data);
      chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd1);
      chk({tag, "_araddr"}, araddr, addr);
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk({tag, "_rready"}, {31'd0, rready}, 32'd1);
      respond(data, addr);
      step();
      rvalid = 1'b0;
      pop_check(tag);
      in_ready = 1'b1;
      step();
      in_ready = 1'b0;
      chk({tag, "_exec_idle"}, {30'd0, arvalid, out_valid}, 32'd0);
   endtask

   // Reset asserted and released between edges; leaves the DUT in REQ.
   task automatic reset_to_req();
      reset = 1'b1;
      #3;
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      reset     = 1'b1;
      arready   = 1'b0;
      rdata     = 32'h0;
      rresp     = 2'b00;
      rvalid    = 1'b0;
      in_ready  = 1'b0;
      npc_valid = 1'b0;
      npc       = 32'h0;

      // Reset state
      #3;
      chk("rst_ctrl", {28'd0, arvalid, rready, out_valid, fetch_err}, 32'd0);
      chk("rst_araddr", araddr, RstPc);
      chk("rst_inst", inst, 32'h0000_0013);
      chk("rst_inst_pc", inst_pc, RstPc);
      step();
      reset = 1'b0;
      chk("boot_no_ar", {31'd0, arvalid}, 32'd0);
      step();

      // 1. Basic fetch, rvalid two cycles after the AR handshake
      chk("t1_arvalid", {31'd0, arvalid}, 32'd1);
      chk("t1_araddr", araddr, RstPc);
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk("t1_wait", {30'd0, arvalid, rready}, 32'd1);
      npc_valid = 1'b1;  // spurious during WAIT
      npc       = 32'h1234_5678;
      step();
      npc_valid = 1'b0;
      respond(32'h0010_0093, RstPc);
      step();
      rvalid = 1'b0;
      pop_check("t1");

      // 2. Backpressure; spurious npc_valid while HOLD
      for (int i = 0; i < 5; i++) begin
         npc_valid = (i == 2);
         npc       = 32'hdead_beec;
         step();
         chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("t2_hold_inst", inst, 32'h0010_0093);
      end
      npc_valid = 1'b0;
      chk("t2_pc_kept", araddr, RstPc);
      in_ready = 1'b1;
      step();
      in_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t2_exec_no_ar", {30'd0, arvalid, out_valid}, 32'd0);
         step();
      end
      npc_valid = 1'b1;
      npc       = 32'h8000_0004;
      step();
      npc_valid = 1'b0;
      chk("t2_next_ar", {31'd0, arvalid}, 32'd1);
      chk("t2_next_addr", araddr, 32'h8000_0004);

      // 3. AR stall with a spurious rvalid during REQ
      rvalid = 1'b1;
      rdata  = 32'hbad0_bad0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_stall_ar", {30'd0, arvalid, rready}, 32'd2);
         chk("t3_stall_addr", araddr, 32'h8000_0004);
      end
      rvalid = 1'b0;
      chk("t3_inst_kept", inst, 32'h0010_0093);
      fetch_ok("t3", 32'h8000_0004, 32'h0020_8113);

      // 4a. Error response; npc_valid afterwards must not restart fetch
      npc_valid = 1'b1;
      npc       = 32'h8000_0008;
      step();
      npc_valid = 1'b0;
      arready   = 1'b1;
      step();
      arready = 1'b0;
      rvalid  = 1'b1;
      rresp   = 2'b10;
      step();
      rvalid = 1'b0;
      rresp  = 2'b00;
      chk("t4a_err", {29'd0, fetch_err, arvalid, rready}, 32'd4);
      for (int i = 0; i < 3; i++) begin
         npc_valid = 1'b1;
         npc       = 32'h8000_0010;
         step();
         chk("t4a_sticky", {30'd0, fetch_err, arvalid}, 32'd2);
      end
      npc_valid = 1'b0;

      // Asynchronous reset clears the error without waiting for an edge
      #2;
      reset = 1'b1;
      #1;
      chk("t4a_async_clr", {31'd0, fetch_err}, 32'd0);
      step();
      reset = 1'b0;
      step();

      // 4b. Misaligned next PC
      fetch_ok("t4b", RstPc, 32'h0000_0533);
      npc_valid = 1'b1;
      npc       = 32'h8000_0002;
      step();
      npc_valid = 1'b0;
      chk("t4b_no_ar", {31'd0, arvalid}, 32'd0);
      step();
      chk("t4b_err", {30'd0, fetch_err, arvalid}, 32'd2);

      // 4c. Timeout after four WAIT cycles
      reset_to_req();
      chk("t4c_ar", {31'd0, arvalid}, 32'd1);
      arready = 1'b1;
      step();
      arready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t4c_waiting", {30'd0, rready, fetch_err}, 32'd2);
         step();
      end
      chk("t4c_last_wait", {30'd0, rready, fetch_err}, 32'd2);
      step();
      chk("t4c_timeout", {30'd0, rready, fetch_err}, 32'd1);

      // 5. Reset mid-WAIT, stale rvalid afterwards
      reset_to_req();
      arready = 1'b1;
      step();
      arready = 1'b0;
      step();
      chk("t5_in_wait", {31'd0, rready}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async", {29'd0, rready, out_valid, fetch_err}, 32'd0);
      chk("t5_araddr", araddr, RstPc);
      rvalid = 1'b1;
      rdata  = 32'hbad0_0001;
      step();
      reset = 1'b0;
      step();
      chk("t5_req", {29'd0, arvalid, rready, out_valid}, 32'd4);
      step();
      chk("t5_stale_ignored", {29'd0, arvalid, rready, out_valid}, 32'd4);
      chk("t5_inst_nop", inst, 32'h0000_0013);
      rvalid = 1'b0;
      fetch_ok("t5", RstPc, 32'h0030_0193);

      chk("sb_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
